// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the multi-cycle serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step counter must hold the value STEPS itself.
  function automatic int unsigned cnt_width(input int unsigned steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit combinational full-adder cell.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_n.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per step, carry held between steps,
// valid/ready handshakes on both operand and result sides.
module serial_adder_n
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW    = cnt_width(STEPS);

  if ((WIDTH < 1) || (BITS_PER_CYCLE < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
    $error("serial_adder_n: WIDTH must be a nonzero multiple of BITS_PER_CYCLE");
  end

  state_e                    state_q, state_d;
  logic [WIDTH-1:0]          a_sr, b_sr;
  logic                      carry_q;
  logic [CW-1:0]             cnt_q;
  logic                      load, step, last;
  logic [BITS_PER_CYCLE-1:0] step_sum;
  logic [BITS_PER_CYCLE:0]   chain;

  // Ripple chain over the low slice of the operand shift registers.
  assign chain[0] = carry_q;
  for (genvar i = 0; i < int'(BITS_PER_CYCLE); i++) begin : g_fa
    full_adder_bit u_fa (
      .a   (a_sr[i]),
      .b   (b_sr[i]),
      .cin (chain[i]),
      .sum (step_sum[i]),
      .cout(chain[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CW'(1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      if (load) begin
        a_sr    <= a;
        b_sr    <= b ^ {WIDTH{sub}};
        carry_q <= cin ^ sub;
        cnt_q   <= CW'(STEPS);
        sum     <= '0;
      end
      if (step) begin
        a_sr    <= a_sr >> BITS_PER_CYCLE;
        b_sr    <= b_sr >> BITS_PER_CYCLE;
        sum     <= (sum >> BITS_PER_CYCLE) | (WIDTH'(step_sum) << (WIDTH - BITS_PER_CYCLE));
        carry_q <= chain[BITS_PER_CYCLE];
        cnt_q   <= cnt_q - CW'(1);
      end
      // On the final step the top cell is bit WIDTH-1.
      if (last) begin
        cout     <= chain[BITS_PER_CYCLE];
        overflow <= chain[BITS_PER_CYCLE] ^ chain[BITS_PER_CYCLE-1];
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed and randomised checks of serial_adder_n at W=8/B=1 and W=8/B=4.
module tb_serial_adder_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v1, r1, ov1, or1, cin1, sub1, co1, ovf1;
  logic [7:0] a1, b1, s1;
  logic       v2, r2, ov2, or2, cin2, sub2, co2, ovf2;
  logic [7:0] a2, b2, s2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(s1),
    .cout(co1), .overflow(ovf1)
  );

  serial_adder_n #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .a(a2), .b(b2),
    .cin(cin2), .sub(sub2), .out_valid(ov2), .out_ready(or2), .sum(s2),
    .cout(co2), .overflow(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an operation to dut1 and wait for its result; returns edges after accept.
  task automatic start1(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic s, output int lat);
    @(negedge clk);
    check("in_ready_before_op", 32'(r1), 32'd1);
    a1 = a; b1 = b; cin1 = c; sub1 = s; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish1(input string tag, input logic [7:0] es, input logic ec,
                         input logic eo);
    check({tag, "_valid"}, 32'(ov1), 32'd1);
    check({tag, "_sum"}, 32'(s1), 32'(es));
    check({tag, "_cout"}, 32'(co1), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf1), 32'(eo));
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
    check({tag, "_valid_cleared"}, 32'(ov1), 32'd0);
    check({tag, "_in_ready_back"}, 32'(r1), 32'd1);
  endtask

  initial begin
    int         lat;
    logic [7:0] hs;
    logic [8:0] full;
    logic [7:0] bx, ea, eb;
    logic       ec_in, eov;

    rst_n = 1'b0;
    v1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; or1 = 0;
    v2 = 0; a2 = 0; b2 = 0; cin2 = 0; sub2 = 0; or2 = 0;
    repeat (3) @(negedge clk);
    v1 = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(ov1), 32'd0);
    check("rst_sum", 32'(s1), 32'd0);
    check("rst_cout", 32'(co1), 32'd0);
    check("rst_ovf", 32'(ovf1), 32'd0);
    check("rst_in_ready", 32'(r1), 32'd1);
    check("rst_in_ready_b4", 32'(r2), 32'd1);
    v1 = 1'b0;
    rst_n = 1'b1;

    // 1. basic add with latency
    start1(8'h0F, 8'h01, 1'b0, 1'b0, lat);
    check("t1_latency", 32'(lat), 32'd8);
    finish1("t1", 8'h10, 1'b0, 1'b0);

    // 2. carry-out, then signed overflow
    start1(8'hFF, 8'h01, 1'b1, 1'b0, lat);
    finish1("t2a", 8'h01, 1'b1, 1'b0);
    start1(8'h7F, 8'h01, 1'b0, 1'b0, lat);
    finish1("t2b", 8'h80, 1'b0, 1'b1);

    // 3. subtraction: borrow, overflow, borrow-in
    start1(8'h05, 8'h07, 1'b0, 1'b1, lat);
    finish1("t3a", 8'hFE, 1'b0, 1'b0);
    start1(8'h80, 8'h01, 1'b0, 1'b1, lat);
    finish1("t3b", 8'h7F, 1'b1, 1'b1);
    start1(8'h10, 8'h03, 1'b1, 1'b1, lat);
    finish1("t3c", 8'h0C, 1'b1, 1'b0);

    // 4. back-pressure with stray in_valid
    start1(8'h3C, 8'h0A, 1'b0, 1'b0, lat);
    hs = s1;
    for (int i = 0; i < 5; i++) begin
      a1 = 8'hAA; b1 = 8'h55; v1 = 1'b1;
      @(negedge clk);
      check("t4_hold_valid", 32'(ov1), 32'd1);
      check("t4_hold_sum", 32'(s1), 32'(hs));
      check("t4_in_ready_low", 32'(r1), 32'd0);
    end
    v1 = 1'b0;
    finish1("t4", 8'h46, 1'b0, 1'b0);

    // 5. reset in the third RUN cycle discards the operation
    @(negedge clk);
    a1 = 8'hF0; b1 = 8'h0F; cin1 = 0; sub1 = 0; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_rst_valid", 32'(ov1), 32'd0);
    check("t5_rst_sum", 32'(s1), 32'd0);
    check("t5_rst_in_ready", 32'(r1), 32'd1);
    repeat (10) @(negedge clk);
    check("t5_no_stale_result", 32'(ov1), 32'd0);
    start1(8'h12, 8'h34, 1'b0, 1'b0, lat);
    check("t5_latency", 32'(lat), 32'd8);
    finish1("t5", 8'h46, 1'b0, 1'b0);

    // 6. random ops on the 4-bit-per-cycle instance
    for (int k = 0; k < 1000; k++) begin
      ea = 8'($urandom); eb = 8'($urandom);
      ec_in = 1'($urandom); eov = 1'($urandom);
      @(negedge clk);
      a2 = ea; b2 = eb; cin2 = ec_in; sub2 = eov; v2 = 1'b1;
      @(negedge clk);
      v2 = 1'b0;
      lat = 0;
      while (!ov2 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      bx   = eb ^ {8{eov}};
      full = {1'b0, ea} + {1'b0, bx} + 9'(ec_in ^ eov);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n_cmp++;
      assert (lat == 2 && ov2 === 1'b1 && s2 === full[7:0] && co2 === full[8] &&
              ovf2 === ((ea[7] == bx[7]) && (full[7] != ea[7]))) else begin
        n_err++;
        $error("FAIL t6_op%0d: observed lat=%0d v=%b sum=%h c=%b o=%b expected lat=2 v=1 sum=%h c=%b o=%b",
               k, lat, ov2, s2, co2, ovf2, full[7:0], full[8],
               (ea[7] == bx[7]) && (full[7] != ea[7]));
      end
      or2 = 1'b1;
      @(negedge clk);
      or2 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
